// File: rtl/switch_ctrl_pkg.sv
// Shared definitions for the switch control front-end.
//   state_t     - FSM encoding (idle / request outstanding / core running)
//   CH_*        - channel indices of the default four-channel build
//   cnt_width() - width of a debounce counter for a given stable-cycle count
package switch_ctrl_pkg;

   typedef enum logic [1:0] {
      StIdle = 2'd0,
      StReq  = 2'd1,
      StRun  = 2'd2
   } state_t;

   localparam int unsigned CH_RED   = 0;
   localparam int unsigned CH_GREEN = 1;
   localparam int unsigned CH_BLUE  = 2;
   localparam int unsigned CH_TRAN  = 3;

   function automatic int unsigned cnt_width(input int unsigned cycles);
      return $clog2(cycles + 1);
   endfunction

endpackage

// File: rtl/switch_debounce.sv
// Single-bit conditioner: SYNC_STAGES-deep synchroniser followed by a
// debounce counter. The debounced output only follows the synchronised input
// after it has differed for DEBOUNCE_CYCLES consecutive cycles.
// Ports:
//   clk  - system clock
//   rst  - asynchronous active-low reset
//   raw  - unsynchronised switch input
//   db   - registered debounced value
module switch_debounce
   import switch_ctrl_pkg::*;
#(
   parameter int unsigned SYNC_STAGES     = 2,
   parameter int unsigned DEBOUNCE_CYCLES = 16
) (
   input  logic clk,
   input  logic rst,
   input  logic raw,
   output logic db
);

   localparam int unsigned CW = cnt_width(DEBOUNCE_CYCLES);

   logic [SYNC_STAGES-1:0] sync_q;
   logic                   synced;
   logic [CW-1:0]          cnt_q, cnt_d;
   logic                   db_d;

   always_ff @(posedge clk or negedge rst) begin
      if (!rst) begin
         sync_q <= '0;
      end else begin
         sync_q <= {sync_q[SYNC_STAGES-2:0], raw};
      end
   end

   assign synced = sync_q[SYNC_STAGES-1];

   // The increment that would reach DEBOUNCE_CYCLES commits the new value
   // instead, so the counter itself never holds DEBOUNCE_CYCLES.
   always_comb begin
      cnt_d = cnt_q;
      db_d  = db;
      if (synced == db) begin
         cnt_d = '0;
      end else if (cnt_q == CW'(DEBOUNCE_CYCLES - 1)) begin
         db_d  = synced;
         cnt_d = '0;
      end else begin
         cnt_d = cnt_q + CW'(1);
      end
   end

   always_ff @(posedge clk or negedge rst) begin
      if (!rst) begin
         cnt_q <= '0;
         db    <= 1'b0;
      end else begin
         cnt_q <= cnt_d;
         db    <= db_d;
      end
   end

endmodule

// File: rtl/switch_ctrl_front.sv
// Control front-end between board switches and the vector processor core.
// Conditions every switch bit, turns the debounced start switch into a start
// event, latches a configuration word and runs a req/ack/done handshake.
// Ports:
//   clk          - system clock
//   rst          - asynchronous active-low reset
//   ch_switches  - raw channel switches, ch0 in LSBs
//   gtype_switch - raw filter-type switch
//   start_switch - raw start switch
//   start_ack    - core accepted the start request (level)
//   core_done    - one-cycle pulse at end of a core run
//   sw_db        - live debounced {gtype, channels}
//   cfg_word     - {gtype, channels} captured at the accepted start event
//   start_req    - start request to the core, held until acknowledged
//   busy         - high while a request or run is outstanding
//   overrun      - sticky: start event arrived while busy
module switch_ctrl_front
   import switch_ctrl_pkg::*;
#(
   parameter int unsigned N_CH            = 4,
   parameter int unsigned CH_W            = 2,
   parameter int unsigned SYNC_STAGES     = 2,
   parameter int unsigned DEBOUNCE_CYCLES = 16,
   parameter int unsigned START_MODE      = 0
) (
   input  logic                 clk,
   input  logic                 rst,
   input  logic [N_CH*CH_W-1:0] ch_switches,
   input  logic                 gtype_switch,
   input  logic                 start_switch,
   input  logic                 start_ack,
   input  logic                 core_done,
   output logic [N_CH*CH_W:0]   sw_db,
   output logic [N_CH*CH_W:0]   cfg_word,
   output logic                 start_req,
   output logic                 busy,
   output logic                 overrun
);

   localparam int unsigned SW_W = N_CH * CH_W + 1;
   localparam int unsigned NUM  = SW_W + 1;

   logic [NUM-1:0] raw_vec;
   logic [NUM-1:0] db_vec;
   logic           start_db;
   logic           start_prev;
   logic           start_evt;
   state_t         state;

   assign raw_vec = {start_switch, gtype_switch, ch_switches};

   for (genvar i = 0; i < NUM; i++) begin : g_db
      switch_debounce #(
         .SYNC_STAGES     (SYNC_STAGES),
         .DEBOUNCE_CYCLES (DEBOUNCE_CYCLES)
      ) u_db (
         .clk (clk),
         .rst (rst),
         .raw (raw_vec[i]),
         .db  (db_vec[i])
      );
   end

   assign sw_db    = db_vec[SW_W-1:0];
   assign start_db = db_vec[SW_W];

   // Mode 0 fires on the rising edge only; mode 1 on either edge.
   assign start_evt = (START_MODE != 0) ? (start_db ^ start_prev)
                                        : (start_db & ~start_prev);

   always_ff @(posedge clk or negedge rst) begin
      if (!rst) begin
         state      <= StIdle;
         start_prev <= 1'b0;
         cfg_word   <= '0;
         start_req  <= 1'b0;
         busy       <= 1'b0;
         overrun    <= 1'b0;
      end else begin
         start_prev <= start_db;
         case (state)
            StIdle: begin
               if (start_evt) begin
                  cfg_word  <= sw_db;
                  start_req <= 1'b1;
                  busy      <= 1'b1;
                  state     <= StReq;
               end
            end
            StReq: begin
               if (start_evt) overrun <= 1'b1;
               if (start_ack) begin
                  start_req <= 1'b0;
                  state     <= StRun;
               end
            end
            StRun: begin
               // A late start_ack is irrelevant here; core_done ends the run and
               // a coincident start event is only flagged, never re-armed.
               if (start_evt) overrun <= 1'b1;
               if (core_done) begin
                  busy  <= 1'b0;
                  state <= StIdle;
               end
            end
            default: begin
               start_req <= 1'b0;
               busy      <= 1'b0;
               state     <= StIdle;
            end
         endcase
      end
   end

endmodule

// File: doc/switch_ctrl_front.md
Name: switch_ctrl_front

Overview:
Parametrised control front-end between the board switches and the vector processor core. It conditions N_CH multi-bit filter-select switch channels, the filter-type switch and the start switch. Conditioning is synchronise plus debounce. On a qualified start event it latches a coherent configuration word and starts the core with a req/ack handshake, then waits for the core's done pulse. It generalises the fixed red/green/blue/transparency/gtype/start switch set to any channel count and width, and adds debounce, toggle-mode start and overrun detection.

Parameters:
N_CH, 4, number of switch channels (ch0=red, ch1=green, ch2=blue, ch3=transparency in the default build)
CH_W, 2, bits per channel
SYNC_STAGES, 2, synchroniser flops per input (min 2)
DEBOUNCE_CYCLES, 16, consecutive stable cycles before a debounced bit changes (min 1)
START_MODE, 0, 0 = start event on debounced rising edge only; 1 = start event on any debounced toggle

Ports:
clk  in  1  system clock
rst  in  1  asynchronous, active-low reset
ch_switches  in  N_CH*CH_W  raw channel switches, ch0 in LSBs
gtype_switch  in  1  raw filter-type switch
start_switch  in  1  raw start switch
start_ack  in  1  core accepted start (level, sampled each clk)
core_done  in  1  one-cycle pulse from core at end of run
sw_db  out  N_CH*CH_W+1  live debounced switches, {gtype, channels}
cfg_word  out  N_CH*CH_W+1  configuration latched at start event, {gtype, channels}
start_req  out  1  start request to core
busy  out  1  high in REQ and RUN
overrun  out  1  sticky: start event seen while busy

Behaviour:
- Reset: rst low asynchronously clears all sync flops, debounce counters, sw_db, cfg_word, start_req, busy and overrun to 0. State goes to IDLE. Release is effective on the next clk edge.
- Each raw bit, start included, passes through SYNC_STAGES flops.
- Each synced bit has its own counter, width $clog2(DEBOUNCE_CYCLES+1).
  - Counter clears whenever synced value equals debounced value.
  - Otherwise it increments.
  - On reaching DEBOUNCE_CYCLES, the debounced value takes the synced value and the counter clears.
  - Net latency from a stable raw change to sw_db change: SYNC_STAGES+DEBOUNCE_CYCLES cycles.
  - A pulse shorter than DEBOUNCE_CYCLES synced cycles never propagates.
- Start event: a one-cycle internal pulse from comparing debounced start with its value registered one cycle earlier. Rising edge only in mode 0, either edge in mode 1.
- FSM, encoding in package:
  - IDLE: start_req=0, busy=0. On start event: cfg_word <= sw_db (same-cycle value), start_req <= 1, go to REQ.
  - REQ: start_req=1, busy=1. When start_ack=1: start_req <= 0, go to RUN. start_req never drops before ack.
  - RUN: busy=1. When core_done=1: go to IDLE, busy <= 0.
- cfg_word changes only on the IDLE->REQ transition. It is stable during REQ and RUN even if the switches move.
- A start event in REQ or RUN sets overrun and is otherwise dropped. overrun clears only on reset.
- core_done in IDLE or REQ is ignored.
- start_ack and core_done in the same RUN cycle: core_done wins and the FSM goes to IDLE.
- Start event and core_done in the same RUN cycle: FSM goes to IDLE and overrun sets. No re-arm.
- Reset asserted mid-REQ/RUN: start_req and busy drop immediately and asynchronously, and no pending event is kept.
- Outputs are registered; no combinational path from any input to any output.

Decomposition:
- Package switch_ctrl_pkg holds:
  - the state enum (IDLE, REQ, RUN) as a 2-bit typedef;
  - the channel index constants (CH_RED=0, CH_GREEN=1, CH_BLUE=2, CH_TRAN=3);
  - a function returning the counter width.
- Sub-module switch_debounce (parameters SYNC_STAGES, DEBOUNCE_CYCLES): one bit with synchroniser and counter. It is instantiated N_CH*CH_W+2 times via generate.

Test Plan (SYNC_STAGES=2, DEBOUNCE_CYCLES=4 unless stated):
1. Reset, then ch_switches=8'h43 (red=3, green=0, blue=0, tran=1), gtype=0 held -> sw_db=9'h043 exactly 6 cycles later. cfg_word stays 0, start_req stays 0.
2. start_switch high for 3 cycles then low -> no start event; start_req, busy and overrun stay 0.
3. start_switch high held 10 cycles -> start_req=1 seven cycles after the rise and cfg_word=9'h043. Hold start_ack=0 for 5 cycles: start_req stays 1. Assert ack: start_req=0 next cycle and busy=1.
4. In RUN, change ch_switches to 8'hFF and press start again -> overrun=1, cfg_word still 9'h043, no new req. Then core_done pulse -> busy=0 next cycle.
5. Toggle switch tracking in START_MODE=1: start falls after 6 stable cycles -> new event, start_req=1. start_ack then core_done returns the FSM to IDLE.
6. rst low asynchronously mid-REQ -> start_req, busy, cfg_word and overrun read 0 before the next clk edge. After release the FSM is in IDLE.
